adc_spi_capture: RTL and testbench

// Serial-ADC frame capture stage fed by the SCLK divider/sample-strobe block. On each sample strobe it

---
 rtl/adc_spi_capture.sv | 149 ++++++++++++++
 tb/tb_adc_spi_capture.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_capture.sv
//------------------------------------------------------------------------------
// adc_spi_capture : frames one serial-ADC conversion per sample strobe, shifts
//                   FRAME_BITS MSB-first on SCLK rises, emits the DATA_BITS LSBs
// Revision        : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adc_spi_capture #(
   parameter int FRAME_BITS  = 16,
   parameter int DATA_BITS   = 12,
   parameter int QUIET_EDGES = 1
) (
   input  logic                 clk_clk,
   input  logic                 reset_n,
   input  logic                 sclk_in,
   input  logic                 sample_start,
   input  logic                 adc_sdata,
   input  logic                 ovr_clr,
   output logic                 adc_cs_n,
   output logic [DATA_BITS-1:0] sample_data,
   output logic                 sample_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam int QW    = (QUIET_EDGES > 1) ? $clog2(QUIET_EDGES) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_SHIFT = 3'd2,
      S_DONE  = 3'd3,
      S_QUIET = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic                   sclk_dly_q;
   logic                   cs_n_q, cs_n_d;
   logic [FRAME_BITS-1:0]  sreg_q, sreg_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [QW-1:0]          q_cnt_q, q_cnt_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   err_q, err_d;
   logic                   valid_q, valid_d;
   logic                   ovr_q, ovr_d;
   logic                   sclk_rise, sclk_fall;
   logic                   lead_err;

   assign sclk_rise = sclk_in & ~sclk_dly_q;
   assign sclk_fall = ~sclk_in & sclk_dly_q;

   // Discard bits only exist when the frame is wider than the sample
   generate
      if (DATA_BITS < FRAME_BITS) begin : g_lead_err
         assign lead_err = |sreg_q[FRAME_BITS-1:DATA_BITS];
      end else begin : g_no_lead_err
         assign lead_err = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      cs_n_d    = cs_n_q;
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      q_cnt_d   = q_cnt_q;
      data_d    = data_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      ovr_d     = ovr_clr ? 1'b0 : ovr_q;
      if (sample_start && (state_q != S_IDLE)) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (sample_start) state_d = S_ARM;
         end
         S_ARM: begin
            if (sclk_fall) begin
               cs_n_d    = 1'b0;
               bit_cnt_d = '0;
               sreg_d    = '0;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (sclk_rise) begin
               sreg_d    = {sreg_q[FRAME_BITS-2:0], adc_sdata};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            data_d  = sreg_q[DATA_BITS-1:0];
            err_d   = lead_err;
            valid_d = 1'b1;
            cs_n_d  = 1'b1;
            q_cnt_d = '0;
            state_d = S_QUIET;
         end
         S_QUIET: begin
            if (sclk_fall) begin
               if (q_cnt_q == QW'(QUIET_EDGES - 1)) state_d = S_IDLE;
               else                                 q_cnt_d = q_cnt_q + QW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         sclk_dly_q <= 1'b0;
         cs_n_q     <= 1'b1;
         sreg_q     <= '0;
         bit_cnt_q  <= '0;
         q_cnt_q    <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sclk_dly_q <= sclk_in;
         cs_n_q     <= cs_n_d;
         sreg_q     <= sreg_d;
         bit_cnt_q  <= bit_cnt_d;
         q_cnt_q    <= q_cnt_d;
         data_q     <= data_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
      end
   end

   assign adc_cs_n     = cs_n_q;
   assign sample_data  = data_q;
   assign sample_valid = valid_q;
   assign frame_err    = err_q;
   assign overrun      = ovr_q;
   assign busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_capture.sv
//------------------------------------------------------------------------------
// tb_adc_spi_capture : randomized self-checking bench with an ADC behavioural model
// Revision           : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_adc_spi_capture;

   localparam int HALF = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sclk = 1'b0;
   logic start1 = 1'b0, sd1 = 1'b0, clr1 = 1'b0;
   logic start2 = 1'b0, sd2 = 1'b0, clr2 = 1'b0;

   logic        cs1, valid1, err1, ovr1, busy1;
   logic [11:0] data1;
   logic        cs2, valid2, err2, ovr2, busy2;
   logic [15:0] data2;

   int errors = 0;
   int checks = 0;
   int rises1 = 0;
   int idx1 = 0;
   int idx2 = 0;
   logic [15:0] word1 = '0;
   logic [15:0] word2 = '0;

   adc_spi_capture #(.FRAME_BITS(16), .DATA_BITS(12), .QUIET_EDGES(1)) u_dut1 (
      .clk_clk(clk), .reset_n(rst_n), .sclk_in(sclk), .sample_start(start1),
      .adc_sdata(sd1), .ovr_clr(clr1), .adc_cs_n(cs1), .sample_data(data1),
      .sample_valid(valid1), .frame_err(err1), .overrun(ovr1), .busy(busy1));

   adc_spi_capture #(.FRAME_BITS(16), .DATA_BITS(16), .QUIET_EDGES(3)) u_dut2 (
      .clk_clk(clk), .reset_n(rst_n), .sclk_in(sclk), .sample_start(start2),
      .adc_sdata(sd2), .ovr_clr(clr2), .adc_cs_n(cs2), .sample_data(data2),
      .sample_valid(valid2), .frame_err(err2), .overrun(ovr2), .busy(busy2));

   always #5 clk = ~clk;

   task automatic pulse_start1();
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
   endtask

   task automatic pulse_clr1();
      @(posedge clk); #1 clr1 = 1'b1;
      @(posedge clk); #1 clr1 = 1'b0;
   endtask

   // Start a frame on DUT1 at a random phase and check the CS_n assertion latency
   task automatic start_frame1(input logic [15:0] w);
      int lat;
      word1  = w;
      rises1 = 0;
      repeat ($urandom_range(0, 30)) @(posedge clk);
      pulse_start1();
      lat = 0;
      while (cs1 !== 1'b0 && lat < 2*HALF + 4) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (cs1 !== 1'b0 || lat > 2*HALF + 3) begin
         errors++;
         $display("FAIL cs_latency: cs_n=%b after %0d cycles, required low within %0d", cs1, lat, 2*HALF + 3);
      end
   endtask

   task automatic wait_valid1(input logic [15:0] w);
      int n;
      logic [11:0] exp_data;
      logic        exp_err;
      exp_data = w[11:0];
      exp_err  = (w >> 12) != 16'd0;
      n = 0;
      while (valid1 !== 1'b1 && n < 20*2*HALF) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (valid1 !== 1'b1) begin
         errors++;
         $display("FAIL valid_timeout: sample_valid=%b, required 1 within %0d cycles", valid1, 20*2*HALF);
      end else begin
         checks++;
         if (data1 !== exp_data) begin
            errors++;
            $display("FAIL sample_data: got %h required %h (word %h)", data1, exp_data, w);
         end
         checks++;
         if (err1 !== exp_err) begin
            errors++;
            $display("FAIL frame_err: got %b required %b (word %h)", err1, exp_err, w);
         end
         checks++;
         if (cs1 !== 1'b1) begin
            errors++;
            $display("FAIL cs_at_valid: got %b required 1", cs1);
         end
         checks++;
         if (rises1 != 16) begin
            errors++;
            $display("FAIL rise_count: got %0d required 16", rises1);
         end
         @(negedge clk);
         checks++;
         if (valid1 !== 1'b0) begin
            errors++;
            $display("FAIL valid_width: got %b required 0 one cycle after pulse", valid1);
         end
      end
   endtask

   task automatic wait_idle1();
      int n;
      n = 0;
      while (busy1 !== 1'b0 && n < 4*HALF) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy1 !== 1'b0) begin
         errors++;
         $display("FAIL idle_timeout: busy=%b required 0", busy1);
      end
   endtask

   task automatic run_frame1(input logic [15:0] w);
      start_frame1(w);
      wait_valid1(w);
      wait_idle1();
   endtask

   task automatic wait_rises1(input int target);
      int n;
      n = 0;
      while (rises1 < target && n < 40*HALF) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rises1 < target) begin
         errors++;
         $display("FAIL rise_wait: got %0d rises required %0d", rises1, target);
      end
   endtask

   // Counts cycles with CS_n low over a window; used to prove no frame starts
   task automatic watch_cs_idle1(input int cycles, input string tag);
      int low;
      low = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (cs1 === 1'b0) low++;
      end
      checks++;
      if (low != 0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL %s: cs_n low for %0d cycles, busy=%b; required 0 and 0", tag, low, busy1);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({cs1, valid1, data1, err1, ovr1, busy1} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_dut1: cs=%b v=%b d=%h e=%b o=%b b=%b required 1 0 000 0 0 0",
                  cs1, valid1, data1, err1, ovr1, busy1);
      end
      checks++;
      if ({cs2, valid2, data2, err2, ovr2, busy2} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_dut2: cs=%b v=%b d=%h e=%b o=%b b=%b required 1 0 0000 0 0 0",
                  cs2, valid2, data2, err2, ovr2, busy2);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      watch_cs_idle1(3*HALF, "idle_after_reset");
   endtask

   task automatic test_basic();
      run_frame1(16'h0ABC);
      run_frame1(16'h8123);
      run_frame1(16'h0FFF);
   endtask

   task automatic test_random();
      logic [31:0] r;
      for (int k = 0; k < 5; k++) begin
         r = $urandom;
         run_frame1(r[15:0]);
      end
   endtask

   task automatic test_overrun();
      start_frame1(16'h0C3A);
      wait_rises1(5);
      pulse_start1();
      @(negedge clk);
      checks++;
      if (ovr1 !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set: got %b required 1", ovr1);
      end
      wait_valid1(16'h0C3A);
      wait_idle1();
      watch_cs_idle1(3*2*HALF, "no_extra_frame");
      checks++;
      if (ovr1 !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky: got %b required 1", ovr1);
      end
      pulse_clr1();
      @(negedge clk);
      checks++;
      if (ovr1 !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clr: got %b required 0", ovr1);
      end
      start_frame1(16'h7001);
      wait_rises1(5);
      @(posedge clk); #1 start1 = 1'b1; clr1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0; clr1 = 1'b0;
      @(negedge clk);
      checks++;
      if (ovr1 !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set_wins: got %b required 1", ovr1);
      end
      wait_valid1(16'h7001);
      wait_idle1();
      pulse_clr1();
   endtask

   task automatic test_abort();
      start_frame1(16'h0F0F);
      wait_rises1(8);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({cs1, valid1, data1, err1, ovr1, busy1} !== {1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_abort: cs=%b v=%b d=%h e=%b o=%b b=%b required 1 0 000 0 0 0",
                  cs1, valid1, data1, err1, ovr1, busy1);
      end
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      run_frame1(16'h0555);
   endtask

   task automatic test_quiet_start();
      start_frame1(16'h0321);
      wait_valid1(16'h0321);
      pulse_start1();
      @(negedge clk);
      checks++;
      if (ovr1 !== 1'b1) begin
         errors++;
         $display("FAIL overrun_quiet: got %b required 1", ovr1);
      end
      watch_cs_idle1(4*2*HALF, "no_frame_from_quiet");
      pulse_clr1();
      run_frame1(16'h0246);
   endtask

   task automatic test_full_width();
      int n;
      int falls;
      logic prev;
      word2 = 16'hBEEF;
      repeat ($urandom_range(0, 20)) @(posedge clk);
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      n = 0;
      while (valid2 !== 1'b1 && n < 20*2*HALF) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (valid2 !== 1'b1 || data2 !== 16'hBEEF || err2 !== 1'b0) begin
         errors++;
         $display("FAIL full_width_frame: v=%b d=%h e=%b required 1 beef 0", valid2, data2, err2);
      end
      prev  = sclk;
      falls = 0;
      n     = 0;
      while (falls < 3 && n < 8*HALF) begin
         @(negedge clk);
         n++;
         if (prev == 1'b1 && sclk == 1'b0) begin
            falls++;
            // The DUT reacts to a fall one clock after the level changes
            checks++;
            if (busy2 !== 1'b1) begin
               errors++;
               $display("FAIL quiet_early: busy=%b at fall %0d required 1", busy2, falls);
            end
         end
         prev = sclk;
      end
      @(negedge clk);
      checks++;
      if (busy2 !== 1'b0 || falls != 3) begin
         errors++;
         $display("FAIL quiet_release: busy=%b after %0d falls required 0 after 3", busy2, falls);
      end
   endtask

   initial begin
      fork
         forever begin
            repeat (HALF) @(posedge clk);
            #1 sclk = ~sclk;
         end
         forever begin
            @(posedge sclk);
            if (cs1 === 1'b0) rises1++;
         end
         forever begin
            @(negedge cs1);
            idx1 = 15;
            sd1  = word1[idx1];
            while (cs1 === 1'b0) begin
               @(negedge sclk or posedge cs1);
               if (cs1 === 1'b0 && idx1 > 0) begin
                  idx1--;
                  sd1 = word1[idx1];
               end
            end
         end
         forever begin
            @(negedge cs2);
            idx2 = 15;
            sd2  = word2[idx2];
            while (cs2 === 1'b0) begin
               @(negedge sclk or posedge cs2);
               if (cs2 === 1'b0 && idx2 > 0) begin
                  idx2--;
                  sd2 = word2[idx2];
               end
            end
         end
         begin
            #2000000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      test_reset();
      test_basic();
      test_random();
      test_overrun();
      test_abort();
      test_quiet_start();
      test_full_width();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
